// File: rtl/ahb5_sub_mem.sv
// ---------------------------------------------------------------------------
// ahb5_sub_mem
//
// AHB5 subordinate backed by a single-port, word-organised memory of
// MEM_DEPTH words. The address phase is registered and the following cycle
// completes the data phase with either a zero-wait OKAY or a two-cycle
// ERROR response. BYTE, HALFWORD and WORD accesses use little-endian byte
// lanes. A read whose address phase overlaps a write data phase to the same
// word returns the merged new data.
//
// Optional build macro: WAIT_STATES_EN
//   When defined, every legal data phase is preceded by WAIT_CYCLES cycles
//   of HREADYOUT=0 (state ST_WAIT). Error responses take no extra waits.
//   When undefined, every legal transfer is zero-wait.
//
// Parameters:
//   DATA_WIDTH  - HWDATA/HRDATA width (only 32 supported)
//   ADDR_WIDTH  - HADDR width
//   MEM_DEPTH   - number of words
//   WAIT_CYCLES - wait states per legal data phase (WAIT_STATES_EN only)
//
// Ports:
//   HCLK       in   clock, rising edge
//   HRESETn    in   asynchronous active-low reset
//   HSEL       in   subordinate select
//   HADDR      in   byte address
//   HTRANS     in   IDLE/BUSY/NONSEQ/SEQ
//   HWRITE     in   1 = write, 0 = read
//   HSIZE      in   BYTE/HALFWORD/WORD
//   HBURST     in   burst type (ignored, each beat handled independently)
//   HWDATA     in   write data, valid in data phase
//   HREADY     in   bus ready (previous transfer complete)
//   HRDATA     out  read data, holds last read value between reads
//   HREADYOUT  out  this subordinate's ready
//   HRESP      out  0 = OKAY, 1 = ERROR
// ---------------------------------------------------------------------------
module ahb5_sub_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int OFFSET = $clog2(MEM_DEPTH);
  localparam int LANES  = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_ERR1 = 3'd2,
    ST_ERR2 = 3'd3
`ifdef WAIT_STATES_EN
    ,
    ST_WAIT = 3'd4
`endif
  } state_t;

  state_t state, state_next;

  // Registered address phase; only the bits that select word and lanes are kept.
  logic [OFFSET+1:0]     addr_q;
  logic                  write_q;
  logic [2:0]            size_q;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  can_accept;
  logic                  accept;
  logic                  xfer_err;
  logic                  wr_en;
  logic [OFFSET-1:0]     wr_idx;
  logic [LANES-1:0]      wr_mask;
  logic                  rd_load;
  logic [OFFSET-1:0]     rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  // Burst type and the SEQ/NONSEQ distinction do not affect decoding.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HTRANS[0]};

`ifdef WAIT_STATES_EN
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam state_t LEGAL_TARGET = (WAIT_CYCLES > 0) ? ST_WAIT : ST_DATA;
  logic [CNT_W-1:0] wait_cnt;
`else
  localparam state_t LEGAL_TARGET = ST_DATA;
`endif

  // A new address phase can only be taken in states that drive HREADYOUT high;
  // BUSY and IDLE (HTRANS[1] == 0) are never accepted.
  always_comb begin
    can_accept = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
    accept     = can_accept && HSEL && HREADY && HTRANS[1];
    xfer_err   = (HSIZE > 3'd2)
               || ((HSIZE == 3'd1) && HADDR[0])
               || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))
               || (HADDR >= MEM_BYTES);
  end

  // Write lane selection from the registered size and low address bits.
  always_comb begin
    wr_en  = (state == ST_DATA) && write_q;
    wr_idx = addr_q[OFFSET+1:2];
    case (size_q)
      3'd0:    wr_mask = 4'b0001 << addr_q[1:0];
      3'd1:    wr_mask = addr_q[1] ? 4'b1100 : 4'b0011;
      default: wr_mask = 4'b1111;
    endcase
  end

  // HRDATA is captured on the edge that enters the read data phase. In the
  // zero-wait path that is the acceptance edge, so the address comes straight
  // from HADDR and a write committing on the same edge is forwarded lane by lane.
  always_comb begin
`ifdef WAIT_STATES_EN
    if (WAIT_CYCLES == 0) begin
      rd_load = accept && !xfer_err && !HWRITE;
      rd_idx  = HADDR[OFFSET+1:2];
    end else begin
      rd_load = (state == ST_WAIT) && (wait_cnt == '0) && !write_q;
      rd_idx  = addr_q[OFFSET+1:2];
    end
`else
    rd_load = accept && !xfer_err && !HWRITE;
    rd_idx  = HADDR[OFFSET+1:2];
`endif
    rd_word = mem[rd_idx];
    for (int b = 0; b < LANES; b++) begin
      if (wr_en && (wr_idx == rd_idx) && wr_mask[b]) begin
        rd_word[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  // Memory array: cleared on reset, lane-masked update on the closing edge
  // of a write data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < LANES; b++) begin
        if (wr_mask[b]) begin
          mem[wr_idx][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  // Address phase register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else if (accept) begin
      addr_q  <= HADDR[OFFSET+1:0];
      write_q <= HWRITE;
      size_q  <= HSIZE;
    end
  end

  // Read data register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rdata_q <= '0;
    end else if (rd_load) begin
      rdata_q <= rd_word;
    end
  end

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

`ifdef WAIT_STATES_EN
  // Wait-state down-counter, loaded when a legal transfer is accepted.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt <= '0;
    end else if (accept && !xfer_err) begin
      wait_cnt <= CNT_LOAD;
    end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end
`endif

  // Next-state and response outputs.
  always_comb begin
    state_next = state;
    HREADYOUT  = 1'b1;
    HRESP      = 1'b0;
    case (state)
      ST_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = 1'b1;
        state_next = ST_ERR2;
      end
`ifdef WAIT_STATES_EN
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (wait_cnt == '0) begin
          state_next = ST_DATA;
        end
      end
`endif
      default: begin
        if (state == ST_ERR2) begin
          HRESP = 1'b1;
        end
        if (accept) begin
          state_next = xfer_err ? ST_ERR1 : LEGAL_TARGET;
        end else begin
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  assign HRDATA = rdata_q;

endmodule

// File: doc/ahb5_sub_mem.md
Name: ahb5_sub_mem

Overview:
- AHB5 subordinate (responder) paired with the AHB5 manager: single-port, word-organised memory of MEM_DEPTH words answering manager transfers.
- Decodes address phase, registers it, completes data phase with OKAY or two-cycle ERROR, supports BYTE/HALFWORD/WORD accesses on little-endian byte lanes.
- Sits behind the interconnect HSEL decode; serves as scoreboard-checkable target for manager-side UVM environment.

Parameters:
- DATA_WIDTH, 32, HWDATA/HRDATA width (only 32 supported).
- ADDR_WIDTH, 32, HADDR width.
- MEM_DEPTH, 64, number of DATA_WIDTH words; word index = HADDR[OFFSET+1:2], OFFSET = $clog2(MEM_DEPTH).
- WAIT_CYCLES, 2, wait states per data phase (used only with WAIT_STATES_EN).

Ports:
- HCLK  in  1  clock, all logic on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  subordinate select.
- HADDR  in  ADDR_WIDTH  byte address.
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ.
- HWRITE  in  1  1=write, 0=read.
- HSIZE  in  3  BYTE/HALFWORD/WORD.
- HBURST  in  3  burst type (informational; each beat handled independently).
- HWDATA  in  DATA_WIDTH  write data, valid in data phase.
- HREADY  in  1  bus ready (previous transfer complete).
- HRDATA  out  DATA_WIDTH  read data.
- HREADYOUT  out  1  this subordinate's ready.
- HRESP  out  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset (async, HRESETn low): HRDATA=0, HREADYOUT=1, HRESP=0, FSM=ST_IDLE, pending write discarded, all memory words cleared to 0.
- Address phase accepted on HCLK edge when HSEL && HREADY && HTRANS in {NONSEQ,SEQ}; HADDR/HWRITE/HSIZE registered.
- HTRANS IDLE/BUSY, or HSEL=0 with HREADY=1: next cycle zero-wait OKAY, no memory access.
- Error check at acceptance: HSIZE>WORD, misaligned (HALFWORD with HADDR[0]=1; WORD with HADDR[1:0]!=0), or HADDR >= MEM_DEPTH*4 -> ERROR.
- FSM states: ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2.
  - ST_IDLE/ST_DATA: accepted legal transfer -> ST_DATA; accepted illegal -> ST_ERR1; none -> ST_IDLE.
  - ST_DATA: HREADYOUT=1, HRESP=0 (zero-wait). Write: byte lanes selected by HSIZE and HADDR[1:0] updated from HWDATA on the closing edge; other lanes untouched. Read: HRDATA = full addressed word (all lanes driven).
  - ST_ERR1: HREADYOUT=0, HRESP=1; always -> ST_ERR2. No memory access.
  - ST_ERR2: HREADYOUT=1, HRESP=1; accepts next address phase like ST_DATA (manager may drive IDLE to cancel).
- Read-after-write: read address phase concurrent with write data phase to same word -> read returns merged new data (forwarding), not stale word.
- HRDATA holds last read value outside read data phases.
- Back-to-back pipelined transfers: one transfer completed per cycle, no bubbles.
- HBURST ignored for decode; SEQ treated identically to NONSEQ; wrap/incr address sequence is manager's responsibility.

Optional Feature:
- Macro WAIT_STATES_EN.
- Defined: each legal data phase preceded by WAIT_CYCLES cycles of HREADYOUT=0, HRESP=0 (state ST_WAIT with down-counter); write committed and HRDATA valid only on final HREADYOUT=1 cycle; error responses unchanged (no extra waits); address phase inputs ignored while HREADY low.
- Undefined: ST_WAIT and counter absent; all legal transfers zero-wait.

Test Plan:
- Reset mid-write (HRESETn low during write data phase) -> HREADYOUT=1, HRESP=0, HRDATA=0, read of that word returns 0x0000_0000.
- WORD write 0xDEADBEEF @0x10, then WORD read @0x10 -> HRDATA=0xDEADBEEF, HRESP=0, HREADYOUT=1 both data phases.
- BYTE write 0xAA @0x11 over word 0x11223344 -> word read @0x10 = 0x1122AA44; HALFWORD write 0x5566 @0x12 -> 0x5566AA44.
- HALFWORD read @0x01 (misaligned) and WORD @0x100 with MEM_DEPTH=64 -> each: cycle1 HREADYOUT=0/HRESP=1, cycle2 HREADYOUT=1/HRESP=1; memory unchanged.
- Pipelined WORD write 0x12345678 @0x20 followed immediately by read @0x20 -> read data phase returns 0x12345678.
- With WAIT_STATES_EN, WAIT_CYCLES=2: WORD read @0x10 -> HREADYOUT low 2 cycles, then high with HRDATA=0xDEADBEEF.
